// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM elastic pipeline stage: N-lane entries, valid/ready handshake with a
// two-entry skid buffer, synchronous flush with a saturating discard counter.
module ex_mem_pipe_reg #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 6,
  parameter int CTRL_W = 6,
  localparam int P     = 2*DATA_W + REG_W + PC_W + CTRL_W,
  localparam int W     = LANES*P
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_lane_valid,
  input  logic [W-1:0]     in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_lane_valid,
  output logic [W-1:0]     out_payload,
  output logic [7:0]       flush_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, stateNext;
  logic [W-1:0]     mainPayload, skidPayload;
  logic [LANES-1:0] mainLaneValid, skidLaneValid;
  logic [7:0]       flushCount;
  logic             inFire, outFire;
  logic             loadMainFromIn, loadMainFromSkid, loadSkid;
  logic [1:0]       heldEntries;

  // Zero the ctrl field of every lane whose keep bit is clear.
  function automatic logic [W-1:0] maskCtrl(input logic [W-1:0] pl, input logic [LANES-1:0] keep);
    logic [W-1:0] r;
    r = pl;
    for (int i = 0; i < LANES; i++)
      if (!keep[i]) r[i*P + P - CTRL_W +: CTRL_W] = '0;
    return r;
  endfunction

  function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign inFire      = in_valid & in_ready;
  assign outFire     = out_valid & out_ready;
  assign heldEntries = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: if (inFire) begin
          stateNext      = ONE;
          loadMainFromIn = 1'b1;
        end
        ONE: begin
          if (inFire && outFire) begin
            loadMainFromIn = 1'b1;
          end else if (inFire) begin
            loadSkid  = 1'b1;
            stateNext = FULL;
          end else if (outFire) begin
            stateNext = EMPTY;
          end
        end
        FULL: if (outFire) begin
          loadMainFromSkid = 1'b1;
          stateNext        = ONE;
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Handshake flags come from registered state only, so out_ready never
  // reaches in_ready combinationally.
  always_comb begin
    in_ready       = (state != FULL);
    out_valid      = (state != EMPTY);
    out_lane_valid = out_valid ? mainLaneValid : '0;
    out_payload    = maskCtrl(mainPayload, out_lane_valid);
    flush_count    = flushCount;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainPayload   <= '0;
      mainLaneValid <= '0;
      skidPayload   <= '0;
      skidLaneValid <= '0;
    end else if (flush) begin
      mainPayload   <= maskCtrl(mainPayload, '0);
      skidPayload   <= maskCtrl(skidPayload, '0);
      mainLaneValid <= '0;
      skidLaneValid <= '0;
    end else begin
      if (loadMainFromIn) begin
        mainPayload   <= in_payload;
        mainLaneValid <= in_lane_valid;
      end else if (loadMainFromSkid) begin
        mainPayload   <= skidPayload;
        mainLaneValid <= skidLaneValid;
      end
      if (loadSkid) begin
        skidPayload   <= in_payload;
        skidLaneValid <= in_lane_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     flushCount <= '0;
    else if (flush) flushCount <= satAdd(flushCount, heldEntries);
  end

endmodule
